// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a synchronous byte FIFO.
//   clk, rst_n : clock and synchronous active-low reset
//   i_rxp      : asynchronous serial line, idle high, LSB first
//   rd_en      : pop request (ignored while empty)
//   rd_data    : popped byte, valid when rd_valid pulses
//   rd_valid   : one-cycle pulse after a successful pop
//   empty      : FIFO holds no bytes
//   frame_err  : one-cycle pulse, stop bit sampled low, byte discarded
//   overrun    : one-cycle pulse, byte arrived while FIFO full, byte dropped
module uart_rx_fifo #(
    parameter int unsigned baud_cycles = 5,
    parameter int unsigned FIFO_DEPTH  = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rxp,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       empty,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(baud_cycles);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(baud_cycles / 2);
    localparam logic [CW-1:0] LAST = CW'(baud_cycles - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic          r_sync1, r_rx_s, r_rx_d;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_stop_ok, w_stop_bad;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic          w_full, w_wr, w_rd, w_start;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid, r_empty, r_frame_err, r_overrun;

    // Two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_rxp;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // Falling edge only, so a line stuck low never starts a frame
    assign w_start   = r_rx_d & ~r_rx_s;
    assign w_cnt_inc = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

    // Receive FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Receive FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_state == ST_IDLE) ? '0 : w_cnt_inc;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == HALF) begin
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Realign so later samples land mid-bit
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (r_cnt == LAST) begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Return to idle mid stop bit so a back-to-back start edge is seen
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_stop_ok   = r_rx_s;
                    w_stop_bad  = ~r_rx_s;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIFO control; full/empty judged on pre-cycle pointers
    assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr   = w_stop_ok & ~w_full;
    assign w_rd   = rd_en & ~r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_rd);

    // Storage array is not reset; the pointers define its contents
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    // Pointers, read port and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_empty     <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_rd_valid  <= w_rd;
            r_empty     <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_stop_ok & w_full;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign empty     = r_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames, predicts received bytes in a queue.
module tb_uart_rx_fifo;

    localparam int unsigned B     = 5;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       i_rxp;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(.baud_cycles(B), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rxp     (i_rxp),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int v0, f0, o0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; the byte is predicted only when the FIFO should accept it
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit store);
        if (store) exp_q.push_back(d);
        i_rxp = 1'b0;
        idle(B);
        for (int i = 0; i < 8; i++) begin
            i_rxp = d[i];
            idle(B);
        end
        i_rxp = stop;
        idle(B);
        i_rxp = 1'b1;
    endtask

    task automatic read_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        idle(2);
    endtask

    // Monitor: every popped byte is compared to the head of the prediction queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                n_valid++;
                if (exp_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
        end
    end

    initial begin
        rst_n = 1'b0;
        i_rxp = 1'b1;
        rd_en = 1'b0;
        idle(3);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        idle(5);

        // 1: single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(5);
        check("t1_empty_low", 32'(empty), 32'd0);
        read_one();
        check("t1_empty_high", 32'(empty), 32'd1);
        check("t1_q_left", 32'(exp_q.size()), 32'd0);

        // 2: back-to-back frames
        f0 = n_ferr;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(5);
        for (int i = 0; i < 3; i++) read_one();
        check("t2_q_left", 32'(exp_q.size()), 32'd0);
        check("t2_ferr", 32'(n_ferr - f0), 32'd0);
        check("t2_empty", 32'(empty), 32'd1);

        // 3: glitch is a false start, then a bad stop bit
        f0 = n_ferr;
        o0 = n_ovr;
        i_rxp = 1'b0;
        idle(1);
        i_rxp = 1'b1;
        idle(20);
        check("t3_glitch_empty", 32'(empty), 32'd1);
        check("t3_glitch_ferr", 32'(n_ferr - f0), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(10);
        check("t3_ferr", 32'(n_ferr - f0), 32'd1);
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_ovr", 32'(n_ovr - o0), 32'd0);

        // 4: overrun on the fifth byte into a depth-4 FIFO
        o0 = n_ovr;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        idle(5);
        check("t4_no_ovr_yet", 32'(n_ovr - o0), 32'd0);
        send_frame(8'h05, 1'b1, 1'b0);
        idle(5);
        check("t4_ovr", 32'(n_ovr - o0), 32'd1);
        for (int i = 0; i < 4; i++) read_one();
        check("t4_q_left", 32'(exp_q.size()), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);

        // 5: continuous read while bytes stream in
        v0 = n_valid;
        rd_en = 1'b1;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'hC7, 1'b1, 1'b1);
        send_frame(8'h6E, 1'b1, 1'b1);
        idle(10);
        rd_en = 1'b0;
        idle(2);
        check("t5_valid_cnt", 32'(n_valid - v0), 32'd3);
        check("t5_q_left", 32'(exp_q.size()), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);

        // 6: reset mid-frame with two bytes buffered
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        idle(5);
        check("t6_pre_empty", 32'(empty), 32'd0);
        i_rxp = 1'b0;
        idle(B);
        i_rxp = 1'b1;
        idle(2 * B + 2);
        rst_n = 1'b0;
        rd_en = 1'b1;
        exp_q.delete();
        idle(3);
        rst_n = 1'b1;
        rd_en = 1'b0;
        idle(1);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        idle(10);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(5);
        read_one();
        check("t6_q_left", 32'(exp_q.size()), 32'd0);
        check("t6_empty_end", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive counterpart of the buffered UART transmit path: takes the 8N1 line driven by the transmit block's o_txp, or by an external device, and recovers bytes.
- Buffers recovered bytes in an internal synchronous FIFO for a downstream consumer (SPI bridge, command parser).
- Contains three parts: a 2-flop input synchroniser, a mid-bit sampling receive FSM, and the FIFO.
- Flags framing errors and FIFO overruns.

Parameters:
- baud_cycles, 5, clk cycles per bit (25 MHz / 5 Mbaud); legal range >= 4.
- FIFO_DEPTH, 128, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- i_rxp  input  1  asynchronous serial line, idle high, LSB first
- rd_en  input  1  pop request; ignored when empty=1
- rd_data  output  8  popped byte, registered
- rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped byte
- empty  output  1  FIFO holds no bytes
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- overrun  output  1  one-cycle pulse: byte received while FIFO full, byte dropped

Behaviour:
- Reset values:
  - Synchroniser flops reset to 1.
  - FSM goes to ST_IDLE; bit counter and baud counter go to 0.
  - FIFO pointers go to 0.
  - Outputs: rd_data=0, rd_valid=0, empty=1, frame_err=0, overrun=0.
- Reset mid-frame or mid-read aborts the frame and clears all buffered data.
- Synchroniser: rx_s is i_rxp after 2 flops; rx_d is rx_s delayed 1 cycle. Start detect = rx_d=1 && rx_s=0 (falling edge only). A line held low from reset never starts a frame.
- Baud counter: cnt runs 0..baud_cycles-1 in every state except IDLE, then wraps to 0. HALF = baud_cycles/2 (integer divide).
- ST_IDLE: on start detect, cnt<=0 and go to ST_START.
- ST_START: at cnt==HALF, sample rx_s.
  - rx_s=1: false start; go to ST_IDLE with no flags.
  - rx_s=0: cnt<=0; go to ST_DATA with bit count 0.
- ST_DATA: at cnt==baud_cycles-1 (mid-bit), shift rx_s into the shift register, LSB first, and increment the bit count. After the 8th sample, go to ST_STOP.
- ST_STOP: at cnt==baud_cycles-1, sample rx_s, then go to ST_IDLE in the same cycle (re-arms mid stop bit so back-to-back frames are caught).
  - rx_s=1 and FIFO not full: write the byte.
  - rx_s=1 and FIFO full: pulse overrun; FIFO unchanged.
  - rx_s=0: pulse frame_err; no write. This takes precedence over overrun.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide. full = MSBs differ and low bits equal; empty = pointers equal.
  - Write takes effect on the stop-sample cycle; empty falls on the next cycle.
  - Read: when rd_en=1 and empty=0, rd_data <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 on the following cycle. rd_data holds its value otherwise.
  - rd_en while empty: no pointer move, rd_valid=0.
  - Simultaneous write and read are both honoured.
  - A write into a full FIFO is dropped even if a read happens in the same cycle; overrun is judged on pre-cycle full.
- Latency:
  - i_rxp edge to start detect is 3 cycles.
  - Start detect to FIFO write is HALF + 9*baud_cycles + 1 cycles.
- Bit counter wraps 7->0; no other arithmetic wraps except the pointers.

Test Plan:
1. baud_cycles=5: drive 0xA5 at exactly 5 clk/bit, then idle -> empty falls once. rd_en pulse -> rd_valid the next cycle with rd_data=0xA5, then empty=1.
2. Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three bytes read in order 0x00, 0xFF, 0x81; frame_err never pulses.
3. Low glitch on i_rxp of 1 clk, then high -> FSM returns to IDLE, empty stays 1, no flags. Likewise 0x3C sent with stop bit 0 -> exactly one frame_err pulse, empty stays 1.
4. FIFO_DEPTH=4: send 5 bytes 0x01..0x05 without reading -> overrun pulses once, on byte 5. Reads return 0x01..0x04, then empty=1.
5. Hold rd_en=1 continuously while a stream of 3 bytes arrives -> each byte pops the cycle after it is written; rd_valid pulses 3 times; empty returns to 1.
6. Assert rst_n=0 mid-data-bit of a frame with 2 bytes buffered -> empty=1 and rd_valid=0 after reset. The next clean frame 0x5A is received correctly.
